// File: rtl/jtframe_pll_seq_if.sv
// rtl/jtframe_pll_seq_if.sv - PLL sequencer control/status bundle
// master: sequencer side; slave: PLL/system side.
interface jtframe_pll_seq_if #(
  parameter int CW = 4
);
  logic          locked;
  logic          relock;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic [CW-1:0] lost_cnt;
  logic [CW-1:0] timeouts;

  modport master (
    input  locked, relock,
    output pll_rst, sys_rst, ready, lost_cnt, timeouts
  );

  modport slave (
    output locked, relock,
    input  pll_rst, sys_rst, ready, lost_cnt, timeouts
  );
endinterface

// File: rtl/jtframe_pll_seq.sv
// rtl/jtframe_pll_seq.sv - PLL bring-up/supervision sequencer
// Optional lock watchdog: JTFRAME_PLL_WATCHDOG_EN.
module jtframe_pll_seq #(
  parameter int RST_LEN    = 16,
  parameter int SETTLE_LEN = 1024,
  parameter int LOCK_TO    = 65536,
  parameter int CW         = 4
) (
  input  logic                clk,
  input  logic                rst,
  jtframe_pll_seq_if.master   pll_if
);

  localparam int MAX_AB  = (RST_LEN > SETTLE_LEN) ? RST_LEN : SETTLE_LEN;
  localparam int CNT_MAX = (MAX_AB > LOCK_TO) ? MAX_AB : LOCK_TO;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {ST_PRST, ST_WAIT, ST_SETTLE, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            lk_m_q, lk_s_q;
  logic            pll_rst_q, sys_rst_q, ready_q;
  logic [CW-1:0]   lost_q, lost_d;
  logic            lost_ev;

`ifdef JTFRAME_PLL_WATCHDOG_EN
  logic [CNTW-1:0] wd_q, wd_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic            tmo_ev;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    lost_ev = 1'b0;
    case (state_q)
      ST_PRST: begin
        if (cnt_q == CNTW'(RST_LEN - 1)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q;
        if (lk_s_q) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (!lk_s_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CNTW'(SETTLE_LEN - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = cnt_q;
        if (!lk_s_q) begin
          state_d = ST_PRST;
          cnt_d   = '0;
          lost_ev = 1'b1;
        end
      end
    endcase

`ifdef JTFRAME_PLL_WATCHDOG_EN
    // wd_q runs across WAIT<->SETTLE bounces; reaching RUN beats a same-cycle timeout
    tmo_ev = 1'b0;
    wd_d   = (state_q == ST_WAIT || state_q == ST_SETTLE) ? wd_q + 1'b1 : '0;
    if ((state_q == ST_WAIT || state_q == ST_SETTLE) && state_d != ST_RUN &&
        wd_q == CNTW'(LOCK_TO - 1)) begin
      state_d = ST_PRST;
      cnt_d   = '0;
      tmo_ev  = 1'b1;
    end
`endif

    if (pll_if.relock) begin
      state_d = ST_PRST;
      cnt_d   = '0;
      lost_ev = 1'b0;
`ifdef JTFRAME_PLL_WATCHDOG_EN
      tmo_ev  = 1'b0;
`endif
    end

    lost_d = (lost_ev && lost_q != '1) ? lost_q + 1'b1 : lost_q;
`ifdef JTFRAME_PLL_WATCHDOG_EN
    tmo_d  = (tmo_ev && tmo_q != '1) ? tmo_q + 1'b1 : tmo_q;
`endif
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PRST;
      cnt_q     <= '0;
      lk_m_q    <= 1'b0;
      lk_s_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      lost_q    <= '0;
`ifdef JTFRAME_PLL_WATCHDOG_EN
      wd_q      <= '0;
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lk_m_q    <= pll_if.locked;
      lk_s_q    <= lk_m_q;
      pll_rst_q <= (state_d == ST_PRST);
      sys_rst_q <= (state_d != ST_RUN);
      ready_q   <= (state_d == ST_RUN);
      lost_q    <= lost_d;
`ifdef JTFRAME_PLL_WATCHDOG_EN
      wd_q      <= wd_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign pll_if.pll_rst  = pll_rst_q;
  assign pll_if.sys_rst  = sys_rst_q;
  assign pll_if.ready    = ready_q;
  assign pll_if.lost_cnt = lost_q;
`ifdef JTFRAME_PLL_WATCHDOG_EN
  assign pll_if.timeouts = tmo_q;
`else
  assign pll_if.timeouts = '0;
`endif

endmodule

// File: tb/tb_jtframe_pll_seq.sv
// tb/tb_jtframe_pll_seq.sv - bench for jtframe_pll_seq
// Directed bring-up/loss/relock/reset steps, then random lock waveforms against a timing model.
module tb_jtframe_pll_seq;
  localparam int RST_LEN    = 16;
  localparam int SETTLE_LEN = 8;
  localparam int LOCK_TO    = 100;
  localparam int CW         = 2;
  localparam int LMAX       = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtframe_pll_seq_if #(.CW(CW)) bus ();

  jtframe_pll_seq #(
    .RST_LEN(RST_LEN), .SETTLE_LEN(SETTLE_LEN), .LOCK_TO(LOCK_TO), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .pll_if(bus.master)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: PLL pulse age (-1 when idle), consecutive synchronized-lock run, wait time, released flag.
  int m_age, m_stable, m_wait, m_lost, m_tmo;
  bit m_rel, m_h1, m_h2;

  function automatic void model_edge(input bit r, input bit lk, input bit rl);
    bit lks;
    lks = m_h2;
    if (r) begin
      m_h1 = 0; m_h2 = 0; m_age = 0; m_rel = 0;
      m_lost = 0; m_tmo = 0; m_stable = 0; m_wait = 0;
      return;
    end
    m_h2 = m_h1;
    m_h1 = lk;
    if (rl) begin
      m_age = 0; m_rel = 0;
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age == RST_LEN) begin m_age = -1; m_stable = 0; m_wait = 0; end
    end else if (m_rel) begin
      if (!lks) begin
        if (m_lost < LMAX) m_lost++;
        m_age = 0; m_rel = 0;
      end
    end else begin
      m_wait++;
      m_stable = lks ? m_stable + 1 : 0;
      if (m_stable == SETTLE_LEN + 1) m_rel = 1;
`ifdef JTFRAME_PLL_WATCHDOG_EN
      if (!m_rel && m_wait == LOCK_TO) begin
        m_age = 0;
        if (m_tmo < LMAX) m_tmo++;
      end
`endif
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit lk, input bit rl);
    @(negedge clk);
    rst = r; bus.locked = lk; bus.relock = rl;
    @(posedge clk);
    model_edge(r, lk, rl);
    #1;
    check("pll_rst",  bus.pll_rst,  32'(m_age >= 0));
    check("sys_rst",  bus.sys_rst,  32'(!m_rel));
    check("ready",    bus.ready,    32'(m_rel));
    check("lost_cnt", bus.lost_cnt, 32'(m_lost));
    check("timeouts", bus.timeouts, 32'(m_tmo));
    check("excl",     bus.sys_rst & bus.ready, 0);
  endtask

  task automatic to_run(output int n);
    n = 0;
    do begin step(0, 1, 0); n++; end while (!bus.ready && n < 300);
  endtask

  task automatic pulse_len(output int k);
    k = 0;
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0);
      if (bus.pll_rst) k++; else break;
    end
  endtask

  int n, k, rises, runlen;
  bit prev, lk_r;
  int exp_lost[4] = '{1, 2, 3, 3};

  initial begin
    bus.locked = 0; bus.relock = 0;
    m_age = 0; m_stable = 0; m_wait = 0; m_lost = 0; m_tmo = 0;
    m_rel = 0; m_h1 = 0; m_h2 = 0;

    step(1, 0, 0);
    check("rst_pll", bus.pll_rst, 1);
    check("rst_sys", bus.sys_rst, 1);
    check("rst_ready", bus.ready, 0);
    check("rst_lost", bus.lost_cnt, 0);

    n = 0;
    for (int i = 0; i < 40; i++) begin step(0, 0, 0); if (bus.pll_rst) n++; end
    check("prst_len", n + 1, RST_LEN);
    to_run(n);
    check("lock_to_release", n, 2 + 1 + SETTLE_LEN);
    check("release_lost", bus.lost_cnt, 0);

    // relock lands on the same cycle the synchronized lock drops
    step(0, 0, 0); step(0, 0, 0);
    check("pre_relock_ready", bus.ready, 1);
    step(0, 0, 1);
    check("relock_ready", bus.ready, 0);
    check("relock_pll", bus.pll_rst, 1);
    check("relock_lost", bus.lost_cnt, 0);
    pulse_len(k);
    check("relock_pulse", k + 1, RST_LEN);
    to_run(n);
    check("relock_release", n, 2 + 1 + SETTLE_LEN);

    for (int d = 0; d < 4; d++) begin
      step(0, 0, 0); step(0, 0, 0);
      check("drop_sys_hold", bus.sys_rst, 0);
      pulse_len(k);
      check("drop_pulse", k, RST_LEN);
      check("drop_lost", bus.lost_cnt, exp_lost[d]);
      to_run(n);
      check("drop_release", n, 2 + 1 + SETTLE_LEN);
    end

    step(0, 0, 0); step(0, 0, 0);
    pulse_len(k);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    step(0, 0, 0);
    check("glitch_sys", bus.sys_rst, 1);
    to_run(n);
    check("glitch_release", n, 2 + 1 + SETTLE_LEN);

    step(0, 0, 0); step(0, 0, 0);
    pulse_len(k);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    step(1, 1, 0);
    check("midrst_pll", bus.pll_rst, 1);
    check("midrst_sys", bus.sys_rst, 1);
    check("midrst_lost", bus.lost_cnt, 0);
    to_run(n);
    check("midrst_release", n, RST_LEN + 1 + SETTLE_LEN);

    step(1, 0, 0);
    prev = bus.pll_rst;
    rises = 0;
    for (int i = 0; i < 259; i++) begin
      step(0, 0, 0);
      if (bus.pll_rst && !prev) rises++;
      prev = bus.pll_rst;
    end
`ifdef JTFRAME_PLL_WATCHDOG_EN
    check("wd_repulses", rises, 2);
    check("wd_timeouts", bus.timeouts, 2);
`else
    check("wd_repulses", rises, 0);
    check("wd_timeouts", bus.timeouts, 0);
    check("wd_held_wait", bus.pll_rst, 0);
`endif

    lk_r = 0; runlen = 0;
    for (int i = 0; i < 3000; i++) begin
      if (runlen == 0) begin
        lk_r = ~lk_r;
        runlen = lk_r ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
      end
      runlen--;
      step(bit'($urandom_range(0, 499) == 0), lk_r, bit'($urandom_range(0, 79) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
